sram_device_model: RTL and testbench
====================================

Name: sram_device_model

Overview:
- Responder end of the 16-bit external SRAM bus. Emulates the asynchronous 16-bit SRAM chip that the memory-stage SRAM controller drives: 18-bit word address, active-low write enable, and a shared bidirectional 16-bit data bus.
- Used as the memory device in system simulation. It is also synthesizable as a block-RAM stand-in on boards without external SRAM.
- Adds a configurable read latency, out-of-range detection and access counters to support verification of the controller.

Parameters:
- DEPTH, 65536, number of 16-bit words implemented; valid addresses are 0..DEPTH-1.
- READ_LAT, 0, read latency in cycles. 0 means combinational (asynchronous) read, which is the mode the controller's timing requires. 1..3 adds registered stages.
- ERR_DATA, 16'hDEAD, value driven for a read of an out-of-range address.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- SRAM_WE_N  input  1  write enable, active low; 1 means read/idle.
- addr  input  18  word address from the controller.
- SRAM_data  inout  16  shared data bus. Sampled when SRAM_WE_N=0; driven by this block only under the read-drive rule below.
- addr_err  output  1  registered; pulses for one cycle after any access with addr >= DEPTH.
- wr_count  output  32  number of accepted write cycles since reset.
- init_busy  output  1  high while the clear sweep runs (see Optional Feature).

Behaviour:
- Reset: addr_err=0, wr_count=0, all read-pipeline valid bits=0, SRAM_data released to Hi-Z.
- Reset does not alter memory contents unless SRAM_INIT_CLEAR_EN is defined.
- FSM has two states: INIT and ACTIVE.
  - Without the macro, the FSM resets directly to ACTIVE.
  - With the macro, it resets to INIT and moves to ACTIVE on the cycle after the sweep writes location DEPTH-1.
- Write, in ACTIVE:
  - At each rising edge with SRAM_WE_N=0 and addr<DEPTH: mem[addr] <= SRAM_data and wr_count += 1.
  - wr_count wraps from 2^32-1 to 0.
  - Back-to-back write cycles (e.g. low half then high half) each commit independently.
- Write with addr>=DEPTH: memory unchanged, wr_count unchanged, addr_err=1 on the next cycle.
- Read, READ_LAT=0: when SRAM_WE_N=1, drive SRAM_data = mem[addr] combinationally (ERR_DATA if addr>=DEPTH).
- Read, READ_LAT=N>0:
  - Each cycle, stage 0 captures {valid=SRAM_WE_N, data=mem[addr]}. The pipeline advances by one stage per cycle.
  - SRAM_data is driven with the tail-stage data only when the tail is valid and SRAM_WE_N=1 in the current cycle.
  - A read therefore appears N cycles after its address was presented.
- Read and write to the same address on the same edge: the read path sees the old data (read-before-write). The new data is visible from the next cycle.
- Bus turnaround: SRAM_data is Hi-Z in any cycle with SRAM_WE_N=0, in INIT, and during reset. There is no drive overlap with the controller.
- X or Z on SRAM_WE_N is treated as read (no write commit).
- addr_err asserts for a read of an out-of-range address presented in the previous cycle, or for a write as above.
- Reset asserted mid-access: any write on that edge is not committed, the pipeline is flushed and the bus is released immediately.

Optional Feature:
- Macro: SRAM_INIT_CLEAR_EN.
- Defined:
  - After reset, the INIT sweep writes 16'h0000 to addresses 0..DEPTH-1, one per cycle, taking DEPTH cycles.
  - init_busy=1 throughout the sweep.
  - Controller writes during INIT are dropped and not counted; the bus stays Hi-Z.
  - A reset during the sweep restarts it from address 0.
- Not defined: no sweep, memory powers up X (simulation) or undefined (hardware), and init_busy is tied to 0.

Test Plan:
- READ_LAT=0, write cycles addr=0x10 data=0x5678 then addr=0x11 data=0x1234, then WE_N=1 with addr=0x10 and then addr=0x11 -> SRAM_data reads 0x5678 then 0x1234; wr_count=2.
- Full controller integration: 32-bit store of 0xCAFEBABE to word address 0x20, then a load from 0x20 -> controller read_data=0xCAFEBABE; mem[0x20]=0xBABE, mem[0x21]=0xCAFE.
- READ_LAT=2, addr=0x05 holding 0xA5A5 presented with WE_N=1 at cycle t -> SRAM_data=0xA5A5 at cycle t+2 and Hi-Z whenever WE_N=0.
- DEPTH=1024, write data 0x1111 to addr 0x400 -> mem unchanged, wr_count unchanged, addr_err=1 for exactly one cycle; a read of 0x400 returns 0xDEAD.
- Reset asserted on the same edge as a write of 0x7777 to 0x3 (mem[0x3]=0x0001 before) -> mem[0x3] stays 0x0001, wr_count=0, bus Hi-Z.
- SRAM_INIT_CLEAR_EN, DEPTH=16 -> init_busy high for 16 cycles after reset; afterwards every address reads 0x0000; a write attempted during INIT is not committed and wr_count stays 0.

Source files
------------

// File: rtl/sram_device_model.sv
// Behavioural/synthesizable model of a 16-bit asynchronous SRAM with optional read latency.
// Optional power-up clear sweep is enabled by defining SRAM_INIT_CLEAR_EN.
module sram_device_model #(
  parameter int unsigned DEPTH    = 65536,
  parameter int unsigned READ_LAT = 0,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SRAM_WE_N,
  input  logic [17:0] addr,
  inout  wire  [15:0] SRAM_data,
  output logic        addr_err,
  output logic [31:0] wr_count,
  output logic        init_busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_ACTIVE} state_e;

  logic [15:0]   mem_q [DEPTH];
  state_e        state_q, state_d;
  logic          addr_err_q, addr_err_d;
  logic [31:0]   wr_count_q, wr_count_d;

  logic          we_req;
  logic          addr_ok;
  logic [AW-1:0] idx;
  logic [15:0]   rd_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          drive;
  logic [15:0]   bus_data;

`ifdef SRAM_INIT_CLEAR_EN
  logic [AW-1:0] sweep_q, sweep_d;
  logic          init_busy_q, init_busy_d;
`endif

  // An X/Z write enable fails this compare, so it behaves as a read.
  assign we_req  = (SRAM_WE_N == 1'b0);
  assign addr_ok = (32'(addr) < DEPTH);
  assign idx     = addr[AW-1:0];
  assign rd_word = addr_ok ? mem_q[idx] : ERR_DATA;

  always_comb begin
    state_d    = state_q;
    addr_err_d = 1'b0;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_waddr  = idx;
    mem_wdata  = SRAM_data;
`ifdef SRAM_INIT_CLEAR_EN
    sweep_d     = sweep_q;
    init_busy_d = init_busy_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef SRAM_INIT_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = 16'h0000;
        if (32'(sweep_q) == DEPTH - 1) begin
          state_d     = ST_ACTIVE;
          init_busy_d = 1'b0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
`else
        state_d = ST_ACTIVE;
`endif
      end
      default: begin
        addr_err_d = !addr_ok;
        if (we_req && addr_ok) begin
          mem_we     = 1'b1;
          wr_count_d = wr_count_q + 32'd1;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SRAM_INIT_CLEAR_EN
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_busy_q <= 1'b1;
`else
      state_q     <= ST_ACTIVE;
`endif
      addr_err_q  <= 1'b0;
      wr_count_q  <= '0;
    end else begin
`ifdef SRAM_INIT_CLEAR_EN
      sweep_q     <= sweep_d;
      init_busy_q <= init_busy_d;
`endif
      state_q     <= state_d;
      addr_err_q  <= addr_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; rst only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_rd
      always_comb begin
        drive    = 1'b0;
        bus_data = rd_word;
        if (rst || (state_q != ST_ACTIVE) || we_req) begin
          drive = 1'b0;
        end else begin
          drive = 1'b1;
        end
      end
    end else begin : g_pipe_rd
      logic [READ_LAT-1:0] vld_q;
      logic [15:0]         dat_q [READ_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= !we_req;
          for (int i = 1; i < READ_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      // Stage 0 reads the array before this edge's write lands: read-before-write.
      always_ff @(posedge clk) begin
        dat_q[0] <= rd_word;
        for (int i = 1; i < READ_LAT; i++) begin
          dat_q[i] <= dat_q[i-1];
        end
      end

      always_comb begin
        drive    = 1'b0;
        bus_data = dat_q[READ_LAT-1];
        if (rst || (state_q != ST_ACTIVE) || we_req || !vld_q[READ_LAT-1]) begin
          drive = 1'b0;
        end else begin
          drive = 1'b1;
        end
      end
    end
  endgenerate

  assign SRAM_data = drive ? bus_data : 16'bz;
  assign addr_err  = addr_err_q;
  assign wr_count  = wr_count_q;
`ifdef SRAM_INIT_CLEAR_EN
  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: a READ_LAT=0 and a READ_LAT=2 instance share one stimulus stream.
// Undriven bus lines pull high, so a released bus reads 16'hFFFF.
module tb_sram_device_model;

  localparam int unsigned DEPTH = 1024;
`ifdef SRAM_INIT_CLEAR_EN
  localparam logic        BUSY_RST = 1'b1;
  localparam logic [15:0] EXP3     = 16'h0000;
`else
  localparam logic        BUSY_RST = 1'b0;
  localparam logic [15:0] EXP3     = 16'h0001;
`endif

  logic        clk = 1'b0;
  logic        rst, we_n, oe;
  logic [17:0] addr;
  logic [15:0] drv;
  tri1  [15:0] bus0, bus2;
  logic        err0, err2, busy0, busy2;
  logic [31:0] cnt0, cnt2;

  assign bus0 = oe ? drv : 16'bz;
  assign bus2 = oe ? drv : 16'bz;

  always #5 clk = ~clk;

  sram_device_model #(.DEPTH(DEPTH), .READ_LAT(0), .ERR_DATA(16'hDEAD)) u_lat0 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .addr(addr), .SRAM_data(bus0),
    .addr_err(err0), .wr_count(cnt0), .init_busy(busy0));

  sram_device_model #(.DEPTH(DEPTH), .READ_LAT(2), .ERR_DATA(16'hDEAD)) u_lat2 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .addr(addr), .SRAM_data(bus2),
    .addr_err(err2), .wr_count(cnt2), .init_busy(busy2));

  typedef struct {
    logic        oe;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        chk_bus;
    logic [15:0] exp_bus;
    logic        exp_err;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [15:0] data;
  } sb_t;

  vec_t        vec [27];
  sb_t         sbq [$];
  logic [15:0] model [DEPTH];
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic o, input logic w, input logic [17:0] a,
                              input logic [15:0] wd, input logic c, input logic [15:0] eb,
                              input logic ee, input logic [31:0] ec);
    vec_t v;
    v.oe = o; v.we_n = w; v.addr = a; v.wdata = wd;
    v.chk_bus = c; v.exp_bus = eb; v.exp_err = ee; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic [15:0] model_rd(input logic [17:0] a);
    return (32'(a) < DEPTH) ? model[a[9:0]] : 16'hDEAD;
  endfunction

  task automatic wait_init();
`ifdef SRAM_INIT_CLEAR_EN
    int n = 0;
    we_n = 1'b0; oe = 1'b1; addr = 18'h010; drv = 16'h1234;
    for (int c = 0; c < int'(DEPTH) + 20; c++) begin
      @(negedge clk);
      if (!busy0) break;
      n++;
      @(posedge clk); #1;
    end
    we_n = 1'b1; oe = 1'b0;
    check("init_busy cycles", 32'(n), DEPTH);
    check("wr_count after init", cnt0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("cleared word 0x10", 32'(bus0), 32'h0000);
    @(posedge clk); #1;
`else
    @(negedge clk);
    check("init_busy tied low", 32'(busy0), 32'd0);
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    vec[0]  = mk(1'b1, 1'b0, 18'h00010, 16'h5678, 1'b0, 16'h0000, 1'b0, 32'd0);
    vec[1]  = mk(1'b1, 1'b0, 18'h00011, 16'h1234, 1'b0, 16'h0000, 1'b0, 32'd1);
    vec[2]  = mk(1'b0, 1'b1, 18'h00010, 16'h0000, 1'b1, 16'h5678, 1'b0, 32'd2);
    vec[3]  = mk(1'b0, 1'b1, 18'h00011, 16'h0000, 1'b1, 16'h1234, 1'b0, 32'd2);
    vec[4]  = mk(1'b1, 1'b0, 18'h00005, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 32'd2);
    vec[5]  = mk(1'b0, 1'b1, 18'h00005, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 32'd3);
    vec[6]  = mk(1'b1, 1'b0, 18'h00400, 16'h1111, 1'b0, 16'h0000, 1'b0, 32'd3);
    vec[7]  = mk(1'b0, 1'b1, 18'h00011, 16'h0000, 1'b1, 16'h1234, 1'b1, 32'd3);
    vec[8]  = mk(1'b0, 1'b1, 18'h00010, 16'h0000, 1'b1, 16'h5678, 1'b0, 32'd3);
    vec[9]  = mk(1'b0, 1'b1, 18'h00400, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 32'd3);
    vec[10] = mk(1'b0, 1'b1, 18'h00005, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 32'd3);
    vec[11] = mk(1'b1, 1'b0, 18'h003FF, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 32'd3);
    vec[12] = mk(1'b0, 1'b1, 18'h003FF, 16'h0000, 1'b1, 16'h0F0F, 1'b0, 32'd4);
    vec[13] = mk(1'b0, 1'b0, 18'h003FF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'd4);
    vec[14] = mk(1'b0, 1'b1, 18'h003FF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'd5);
    vec[15] = mk(1'b0, 1'b1, 18'h3FFFF, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 32'd5);
    vec[16] = mk(1'b0, 1'b1, 18'h00010, 16'h0000, 1'b1, 16'h5678, 1'b1, 32'd5);
    vec[17] = mk(1'b1, 1'b0, 18'h00010, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 32'd5);
    vec[18] = mk(1'b1, 1'b0, 18'h00010, 16'h5555, 1'b0, 16'h0000, 1'b0, 32'd6);
    vec[19] = mk(1'b0, 1'b1, 18'h00010, 16'h0000, 1'b1, 16'h5555, 1'b0, 32'd7);
    vec[20] = mk(1'b0, 1'b1, 18'h00005, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 32'd7);
    vec[21] = mk(1'b0, 1'b1, 18'h00005, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 32'd7);
    vec[22] = mk(1'b0, 1'b1, 18'h00400, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 32'd7);
    vec[23] = mk(1'b0, 1'b1, 18'h00010, 16'h0000, 1'b1, 16'h5555, 1'b1, 32'd7);
    vec[24] = mk(1'b1, 1'b0, 18'h00000, 16'h0BAD, 1'b0, 16'h0000, 1'b0, 32'd7);
    vec[25] = mk(1'b1, 1'b0, 18'h00400, 16'h1111, 1'b0, 16'h0000, 1'b0, 32'd8);
    vec[26] = mk(1'b0, 1'b1, 18'h00000, 16'h0000, 1'b1, 16'h0BAD, 1'b1, 32'd8);

    rst = 1'b1; we_n = 1'b1; oe = 1'b0; addr = 18'h0; drv = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset bus lat0 released", 32'(bus0), 32'hFFFF);
    check("reset bus lat2 released", 32'(bus2), 32'hFFFF);
    check("reset addr_err", 32'(err0), 32'd0);
    check("reset wr_count lat0", cnt0, 32'd0);
    check("reset wr_count lat2", cnt2, 32'd0);
    check("reset init_busy lat0", 32'(busy0), 32'(BUSY_RST));
    check("reset init_busy lat2", 32'(busy2), 32'(BUSY_RST));
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init();

    for (int i = 0; i < 27; i++) begin
      oe = vec[i].oe; we_n = vec[i].we_n; addr = vec[i].addr; drv = vec[i].wdata;
      @(negedge clk);
      check($sformatf("v%0d addr_err lat0", i), 32'(err0), 32'(vec[i].exp_err));
      check($sformatf("v%0d addr_err lat2", i), 32'(err2), 32'(vec[i].exp_err));
      check($sformatf("v%0d wr_count lat0", i), cnt0, vec[i].exp_cnt);
      check($sformatf("v%0d wr_count lat2", i), cnt2, vec[i].exp_cnt);
      if (vec[i].chk_bus) check($sformatf("v%0d bus lat0", i), 32'(bus0), 32'(vec[i].exp_bus));
      sbq.push_back('{vld: we_n, data: model_rd(addr)});
      if (sbq.size() > 2) e = sbq.pop_front();
      else e = '{vld: 1'b0, data: 16'h0000};
      if (we_n) check($sformatf("v%0d bus lat2", i), 32'(bus2), e.vld ? 32'(e.data) : 32'hFFFF);
      else if (!oe) check($sformatf("v%0d bus lat2 released", i), 32'(bus2), 32'hFFFF);
      if (!we_n && (32'(addr) < DEPTH)) model[addr[9:0]] = oe ? drv : 16'hFFFF;
      @(posedge clk); #1;
    end

    // Reset landing on the same edge as a write must not commit it.
    we_n = 1'b0; oe = 1'b1; addr = 18'h3; drv = 16'h0001;
    @(posedge clk); #1;
    drv = 16'h7777; rst = 1'b1;
    @(negedge clk);
    check("async reset clears wr_count", cnt0, 32'd0);
    @(posedge clk); #1;
    we_n = 1'b1; oe = 1'b0;
    @(negedge clk);
    check("reset read bus lat0 released", 32'(bus0), 32'hFFFF);
    check("reset read bus lat2 released", 32'(bus2), 32'hFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init();
    we_n = 1'b0; oe = 1'b1; addr = 18'h5; drv = 16'hA5A5;
    repeat (2) begin @(posedge clk); #1; end
    we_n = 1'b1; oe = 1'b0; addr = 18'h3;
    @(negedge clk);
    check("word 3 after reset lat0", 32'(bus0), 32'(EXP3));
    check("lat2 tail empty t+0", 32'(bus2), 32'hFFFF);
    check("wr_count after reset", cnt0, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat2 tail empty t+1", 32'(bus2), 32'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    check("word 3 after reset lat2 t+2", 32'(bus2), 32'(EXP3));
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
